// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched PATTERN_W-bit pattern MSB first,
// rep+1 times back to back, then pulses done for one cycle.
module sequence_generator #(
  parameter int PATTERN_W = 6,
  parameter int REP_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [REP_W-1:0]     rep,
  output logic                 x,
  output logic                 x_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [IW-1:0] TOP = IW'(PATTERN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [PATTERN_W-1:0] pat_q;  // pattern captured at start
  logic [IW-1:0]        idx;    // index of the bit currently on x
  logic [REP_W-1:0]     cnt;    // passes remaining after the current one

  // Single FSM: all outputs are registered and change with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pat_q   <= '0;
      idx     <= '0;
      cnt     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            // First bit goes out on the very edge that accepts start.
            pat_q   <= pattern;
            cnt     <= rep;
            idx     <= TOP;
            x       <= pattern[PATTERN_W-1];
            x_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (idx == '0) begin
            if (cnt == '0) begin
              // Last bit of last pass has been shown: finish with a done pulse.
              state   <= IDLE;
              x       <= 1'b0;
              x_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              // Wrap to the MSB for the next pass with no gap cycle.
              cnt <= cnt - 1'b1;
              idx <= TOP;
              x   <= pat_q[PATTERN_W-1];
            end
          end else begin
            idx <= idx - 1'b1;
            x   <= pat_q[idx - 1'b1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations and a
// randomized soak phase.
module tb_sequence_generator;

  localparam int PW = 6;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [RW-1:0] rep = '0;
  logic          x, x_valid, busy, done;

  int checks = 0;
  int passes = 0;

  sequence_generator #(.PATTERN_W(PW), .REP_W(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .rep(rep),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a transfer is simply the list of bits it must emit.
  // The front of the queue is the bit currently expected on x.
  bit   mq[$];
  logic mx = 1'b0, mv = 1'b0, md = 1'b0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      md = 1'b0;
    end else if (mv) begin
      void'(mq.pop_front());
      if (abort) begin
        mq.delete();
        md = 1'b0;
      end else begin
        md = (mq.size() == 0);
      end
    end else begin
      md = 1'b0;
      if (start && !abort)
        for (int c = 0; c <= int'(rep); c++)
          for (int b = PW - 1; b >= 0; b--) mq.push_back(pattern[b]);
    end
    mv = (mq.size() > 0);
    mx = mv ? mq[0] : 1'b0;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  bit run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("x", 64'(x), 64'(mx));
      chk("x_valid", 64'(x_valid), 64'(mv));
      chk("busy", 64'(busy), 64'(mv));
      chk("done", 64'(done), 64'(md));
    end
  end

  // One start pulse, then watch a fixed window collecting the emitted bits.
  task automatic xfer(input logic [PW-1:0] p, input logic [RW-1:0] r,
                      output logic [127:0] cap, output int nv, output int nd);
    int win;
    cap = '0; nv = 0; nd = 0;
    win = PW * (int'(r) + 1) + 3;
    @(negedge clk);
    start = 1'b1; pattern = p; rep = r;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < win; k++) begin
      if (x_valid) begin cap = {cap[126:0], x}; nv++; end
      if (done) nd++;
      @(negedge clk);
    end
  endtask

  logic [127:0] cap;
  int nv, nd;

  initial begin
    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("reset_outs", 64'({x, x_valid, busy, done}), 64'h0);
    reset = 1'b1;
    run_cmp = 1'b1;
    @(negedge clk);

    // Single pass of 101010.
    xfer(6'b101010, 4'd0, cap, nv, nd);
    chk("single_bits", 64'(cap[5:0]), 64'h2a);
    chk("single_nvalid", 64'(nv), 64'd6);
    chk("single_done", 64'(nd), 64'd1);

    // Three passes: 18 contiguous bits.
    xfer(6'b101010, 4'd2, cap, nv, nd);
    chk("rep2_bits", 64'(cap[17:0]), 64'h2aaaa);
    chk("rep2_nvalid", 64'(nv), 64'd18);
    chk("rep2_done", 64'(nd), 64'd1);

    // Maximum rep gives 16 passes.
    xfer(6'b100001, 4'd15, cap, nv, nd);
    chk("repmax_nvalid", 64'(nv), 64'd96);
    chk("repmax_done", 64'(nd), 64'd1);
    chk("repmax_tail", 64'(cap[11:0]), 64'h861);

    // start and new pattern during SHIFT are ignored.
    cap = '0; nv = 0; nd = 0;
    @(negedge clk);
    start = 1'b1; pattern = 6'b101010; rep = 4'd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin start = 1'b1; pattern = 6'b111111; rep = 4'd3; end
      if (k == 3) start = 1'b0;
      if (x_valid) begin cap = {cap[126:0], x}; nv++; end
      if (done) nd++;
      @(negedge clk);
    end
    chk("ignore_bits", 64'(cap[5:0]), 64'h2a);
    chk("ignore_nvalid", 64'(nv), 64'd6);
    chk("ignore_done", 64'(nd), 64'd1);

    // Abort at the 4th bit: no done, then a clean transfer of 110011.
    cap = '0; nv = 0; nd = 0;
    start = 1'b1; pattern = 6'b101010; rep = 4'd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) abort = 1'b1;
      if (k == 4) abort = 1'b0;
      if (x_valid) begin cap = {cap[126:0], x}; nv++; end
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_nvalid", 64'(nv), 64'd4);
    chk("abort_bits", 64'(cap[3:0]), 64'ha);
    chk("abort_done", 64'(nd), 64'd0);
    xfer(6'b110011, 4'd0, cap, nv, nd);
    chk("after_abort_bits", 64'(cap[5:0]), 64'h33);
    chk("after_abort_done", 64'(nd), 64'd1);

    // abort wins over start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_wins", 64'({x_valid, busy}), 64'h0);
    @(negedge clk);

    // Asynchronous reset between edges mid-transfer.
    start = 1'b1; pattern = 6'b101010; rep = 4'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", 64'({x, x_valid, busy, done}), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("reset_no_done", 64'(nd), 64'd0);
    xfer(6'b101010, 4'd0, cap, nv, nd);
    chk("post_reset_bits", 64'(cap[5:0]), 64'h2a);

    // start held high: bursts separated by one done cycle.
    nv = 0; nd = 0;
    start = 1'b1; pattern = 6'b101010; rep = 4'd0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (x_valid) nv++;
      if (done) nd++;
      if (k == 7 || k == 14 || k == 21)
        chk("held_gap", 64'({x_valid, done}), 64'h1);
    end
    start = 1'b0;
    chk("held_nvalid", 64'(nv), 64'd18);
    chk("held_done", 64'(nd), 64'd3);

    // Randomized soak, checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 40) == 0);
      pattern = PW'($urandom);
      rep     = ($urandom_range(0, 9) == 0) ? RW'($urandom) : RW'($urandom_range(0, 2));
      if ($urandom_range(0, 400) == 0) begin
        #3 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0;
    repeat (120) @(negedge clk);
    run_cmp = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter PATTERN_W, default 6: serial pattern length in bits; legal range is 2 to 32.
REQ-002 Parameter REP_W, default 4: width of the repeat-count input.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: request to transmit; sampled on each rising clk edge.
REQ-006 Port abort, input, 1: synchronous stop of the current transmission.
REQ-007 Port pattern, input, PATTERN_W: bit pattern to send, MSB first; 6'b101010 is the nominal use.
REQ-008 Port rep, input, REP_W: number of extra passes; a transfer sends rep+1 copies of the pattern.
REQ-009 Port x, output, 1: serial data bit; registered.
REQ-010 Port x_valid, output, 1: high while x carries a pattern bit; registered.
REQ-011 Port busy, output, 1: high while state is SHIFT; registered.
REQ-012 Port done, output, 1: one-cycle pulse on normal completion; registered.

Function
REQ-013 The block SHALL implement FSM states IDLE and SHIFT, with a bit index and a pass counter.
REQ-014 In IDLE with start=1 and abort=0 at a clk edge, the block SHALL:
- latch pattern and rep;
- enter SHIFT;
- drive x=pattern[PATTERN_W-1] and x_valid=1 from that edge.
- Zero-cycle latency: the first bit appears in the cycle after start is sampled.
REQ-015 In SHIFT, each clk edge SHALL advance x to the next lower bit of the latched pattern.
REQ-016 After bit 0 of a pass, if passes remain, the next edge SHALL restart at bit PATTERN_W-1 with no gap cycle.
REQ-017 After bit 0 of the final pass, the next edge SHALL:
- enter IDLE;
- drive x=0, x_valid=0, busy=0;
- pulse done=1 for exactly that one cycle.
REQ-018 A transfer SHALL hold x_valid high for exactly PATTERN_W*(rep+1) consecutive cycles.
REQ-019 The pass counter SHALL be REP_W bits and count rep down to 0 with no wrap. rep at its maximum value gives 2^REP_W passes.
REQ-020 start in SHIFT SHALL be ignored. Changes to pattern or rep during SHIFT SHALL NOT affect the transfer in progress.
REQ-021 start sampled in the done cycle (state IDLE) SHALL be accepted, giving back-to-back transfers with exactly one x_valid=0 cycle between them.
REQ-022 abort=1 in SHIFT SHALL force IDLE at the next edge with x=0, x_valid=0, busy=0, done=0.
REQ-023 abort and start both high in IDLE: abort SHALL win and no transfer starts.
REQ-024 Whenever x_valid=0, x SHALL be 0.
REQ-025 busy SHALL equal (state==SHIFT), and busy SHALL equal x_valid at all times.

Reset
REQ-026 reset low SHALL immediately, independent of clk, force:
- state to IDLE;
- x=0, x_valid=0, busy=0, done=0;
- counters cleared.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer; no done SHALL follow.
REQ-028 After reset deasserts, the first accepted start SHALL behave exactly as REQ-014.

Verification
REQ-029 Scenario: pattern=101010, rep=0, one-cycle start -> x=1,0,1,0,1,0 with x_valid high for 6 cycles, then done=1 for 1 cycle, then idle.
REQ-030 Scenario: pattern=101010, rep=2 -> 18 contiguous valid bits (101010 three times), then a single done pulse.
REQ-031 Scenario: start pulsed at the 3rd bit of a rep=0 transfer, and pattern changed to 111111 -> output is still 101010, and only one done pulse occurs.
REQ-032 Scenario: abort at the 4th bit -> x_valid falls at the next edge, x=0, no done. A following start with 110011 -> 110011 is sent.
REQ-033 Scenario: reset low at bit 2 asynchronously, between edges -> all outputs 0 immediately. After release, start -> full 101010.
REQ-034 Scenario: start held high continuously with rep=0 -> repeated 6-bit bursts separated by exactly one x_valid=0 done cycle.
